// File: rtl/rf_wr_arbiter.sv
// Register file with round-robin multi-source write arbiter; write/ack visible 1 cycle after grant.
// Losers hold req/sel/data until acked; reads are combinational with no write bypass.
module rf_wr_arbiter #(
  parameter int data_width    = 32,
  parameter int num_regs      = 32,
  parameter int num_srcs      = 4,
  parameter int reg_sel_width = $clog2(num_regs),
  parameter int src_sel_width = $clog2(num_srcs)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [num_srcs-1:0]               wr_req,
  input  logic [num_srcs*reg_sel_width-1:0] wr_sel,
  input  logic [num_srcs*data_width-1:0]    wr_data,
  output logic [num_srcs-1:0]               wr_ack,
  input  logic [reg_sel_width-1:0]          rd_sel0,
  output logic [data_width-1:0]             rd_data0,
  input  logic [reg_sel_width-1:0]          rd_sel1,
  output logic [data_width-1:0]             rd_data1
);

  localparam int NumSlots = 1 << reg_sel_width;
  localparam logic [src_sel_width:0] NumSrcsW = (src_sel_width + 1)'(num_srcs);

  logic [data_width-1:0]    regs_q [NumSlots];
  logic [num_srcs-1:0]      ack_q, ack_d, elig;
  logic [src_sel_width-1:0] ptr_q, ptr_d, gnt_idx, cand;
  logic [src_sel_width:0]   sum;
  logic                     gnt_vld, wr_en;
  logic [reg_sel_width-1:0] gnt_sel;
  logic [data_width-1:0]    gnt_data;
  logic [reg_sel_width-1:0] sel_arr  [num_srcs];
  logic [data_width-1:0]    data_arr [num_srcs];
  logic [NumSlots-1:0]      writable;

  // Slot 0 and slots beyond num_regs are never written, so they read as their reset value 0.
  for (genvar r = 0; r < NumSlots; r++) begin : g_wmask
    assign writable[r] = (r != 0) && (r < num_regs);
  end

  for (genvar i = 0; i < num_srcs; i++) begin : g_unpack
    assign sel_arr[i]  = wr_sel[i*reg_sel_width +: reg_sel_width];
    assign data_arr[i] = wr_data[i*data_width +: data_width];
  end

  always_comb begin
    elig    = wr_req & ~ack_q;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    sum     = '0;
    cand    = '0;
    for (int k = 1; k <= num_srcs; k++) begin
      sum = {1'b0, ptr_q} + (src_sel_width + 1)'(k);
      if (sum >= NumSrcsW) sum = sum - NumSrcsW;
      cand = sum[src_sel_width-1:0];
      if (!gnt_vld && elig[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    ack_d    = '0;
    ptr_d    = ptr_q;
    gnt_sel  = sel_arr[gnt_idx];
    gnt_data = data_arr[gnt_idx];
    wr_en    = gnt_vld && writable[gnt_sel];
    if (gnt_vld) begin
      ack_d[gnt_idx] = 1'b1;
      ptr_d          = gnt_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q <= '0;
      ptr_q <= src_sel_width'(num_srcs - 1);
      for (int r = 0; r < NumSlots; r++) regs_q[r] <= '0;
    end else begin
      ack_q <= ack_d;
      ptr_q <= ptr_d;
      if (wr_en) regs_q[gnt_sel] <= gnt_data;
    end
  end

  assign wr_ack   = ack_q;
  assign rd_data0 = regs_q[rd_sel0];
  assign rd_data1 = regs_q[rd_sel1];

endmodule
